// File: rtl/oflow_cr_lut_pkg.sv
// rtl/oflow_cr_lut_pkg.sv - shared types and default sizes for the conflict-resolve LUT controller
package oflow_cr_lut_pkg;

  localparam int ADDR_WIDTH_LUT = 11;
  localparam int DATA_WIDTH_LUT = 16;
  localparam int DEPTH_LUT      = 2048;
  localparam int STARVE_TH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2,
    SERVE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CR   = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/oflow_cr_lut_arb.sv
// rtl/oflow_cr_lut_arb.sv - CR-priority arbiter with debug starvation escape
module oflow_cr_lut_arb #(
  parameter int STARVE_TH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cr_req,
  input  logic dbg_req,
  output logic cr_gnt,
  output logic dbg_gnt
);

  localparam int CW = $clog2(STARVE_TH + 1);
  localparam logic [CW-1:0] TH = CW'(STARVE_TH);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  // Grant decision: debug only preempts CR once it has been denied STARVE_TH times in a row
  always_comb begin
    cr_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    starved = (starve_cnt == TH);
    if (en) begin
      if (dbg_req && starved) begin
        dbg_gnt = 1'b1;
      end else if (cr_req) begin
        cr_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  // Consecutive-denial counter; frozen while arbitration is disabled so CLEAR does not build up credit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (en) begin
      if (!dbg_req || dbg_gnt) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/oflow_cr_lut_ctrl.sv
// rtl/oflow_cr_lut_ctrl.sv - zero-fill sequencer and port sharer for the conflict-resolve LUT
module oflow_cr_lut_ctrl
  import oflow_cr_lut_pkg::*;
#(
  parameter int ADDR_W    = ADDR_WIDTH_LUT,
  parameter int DATA_W    = DATA_WIDTH_LUT,
  parameter int DEPTH     = DEPTH_LUT,
  parameter int STARVE_TH = STARVE_TH_DEF
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start_clear,
  output logic              clear_done,
  output logic              busy,
  input  logic              cr_req,
  input  logic              cr_we,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [DATA_W-1:0] cr_wdata,
  output logic              cr_gnt,
  output logic              cr_rvalid,
  output logic [DATA_W-1:0] cr_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Extra counter bit lets DEPTH == 2^ADDR_W terminate without wrapping
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;
  logic [ADDR_W-1:0] addr_hold;
  owner_t            owner;
  logic [DATA_W-1:0] cr_rdata_q, dbg_rdata_q;
  logic              arb_en;

  oflow_cr_lut_arb #(
    .STARVE_TH (STARVE_TH)
  ) u_arb (
    .clk     (clk),
    .rst     (reset_N),
    .en      (arb_en),
    .cr_req  (cr_req),
    .dbg_req (dbg_req),
    .cr_gnt  (cr_gnt),
    .dbg_gnt (dbg_gnt)
  );

  // State and clear-counter registers
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state; a start_clear anywhere (including mid-CLEAR) restarts the fill from address 0
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (start_clear) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        if (start_clear) begin
          clr_cnt_nxt = '0;
        end else if (clr_cnt == LAST) begin
          state_nxt   = DONE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + (ADDR_W + 1)'(1);
        end
      end
      DONE: begin
        clr_cnt_nxt = '0;
        state_nxt   = start_clear ? CLEAR : SERVE;
      end
      SERVE: begin
        if (start_clear) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Memory pin drive: fill writes in CLEAR, the granted access in SERVE, otherwise park on last address
  always_comb begin
    busy       = (state == CLEAR);
    clear_done = (state == DONE);
    arb_en     = (state == SERVE);
    mem_we     = 1'b0;
    mem_addr   = addr_hold;
    mem_wdata  = '0;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt[ADDR_W-1:0];
    end else if (cr_gnt) begin
      mem_we    = cr_we;
      mem_addr  = cr_addr;
      mem_wdata = cr_we ? cr_wdata : '0;
    end else if (dbg_gnt) begin
      mem_addr = dbg_addr;
    end
  end

  // Read-return tracking: remember who issued the read and keep each owner's last returned word
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      owner       <= OWN_NONE;
      addr_hold   <= '0;
      cr_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      addr_hold <= mem_addr;
      if (cr_gnt && !cr_we) begin
        owner <= OWN_CR;
      end else if (dbg_gnt) begin
        owner <= OWN_DBG;
      end else begin
        owner <= OWN_NONE;
      end
      if (owner == OWN_CR) begin
        cr_rdata_q <= mem_rdata;
      end
      if (owner == OWN_DBG) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  // Return path: present the memory word in the cycle it arrives, the held copy afterwards
  always_comb begin
    cr_rvalid  = (owner == OWN_CR);
    dbg_rvalid = (owner == OWN_DBG);
    cr_rdata   = cr_rvalid  ? mem_rdata : cr_rdata_q;
    dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
  end

endmodule

// File: tb/tb_oflow_cr_lut_ctrl.sv
// tb/tb_oflow_cr_lut_ctrl.sv - directed self-checking bench for oflow_cr_lut_ctrl
module tb_oflow_cr_lut_ctrl;

  logic        clk = 1'b0;
  logic        reset_N = 1'b1;
  logic        start_clear = 1'b0;
  logic        clear_done, busy;
  logic        cr_req = 1'b0, cr_we = 1'b0;
  logic [10:0] cr_addr = '0;
  logic [15:0] cr_wdata = '0;
  logic        cr_gnt, cr_rvalid;
  logic [15:0] cr_rdata;
  logic        dbg_req = 1'b0;
  logic [10:0] dbg_addr = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata = '0;

  logic [15:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oflow_cr_lut_ctrl dut (
    .clk         (clk),
    .reset_N     (reset_N),
    .start_clear (start_clear),
    .clear_done  (clear_done),
    .busy        (busy),
    .cr_req      (cr_req),
    .cr_we       (cr_we),
    .cr_addr     (cr_addr),
    .cr_wdata    (cr_wdata),
    .cr_gnt      (cr_gnt),
    .cr_rvalid   (cr_rvalid),
    .cr_rdata    (cr_rdata),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  // Write-first synchronous RAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        cr_req;
    logic        cr_we;
    logic [10:0] cr_addr;
    logic [15:0] cr_wdata;
    logic        dbg_req;
    logic [10:0] dbg_addr;
    logic        e_cr_gnt;
    logic        e_dbg_gnt;
    logic        e_we;
    logic [10:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_cr_rv;
    logic [15:0] e_cr_rd;
    logic        e_dbg_rv;
    logic [15:0] e_dbg_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_a();
    return {39'd0, clear_done, busy, cr_gnt, cr_rvalid, dbg_gnt, dbg_rvalid, mem_we, mem_addr, 7'd0};
  endfunction

  function automatic logic [63:0] outs_b();
    return {16'd0, cr_rdata, dbg_rdata, mem_wdata};
  endfunction

  // All tasks enter and leave one time unit after a rising edge
  task automatic pulse_start();
    start_clear = 1'b1;
    @(posedge clk); #1;
    start_clear = 1'b0;
  endtask

  task automatic clear_walk(input int first, input int n, input bit expect_done);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("clear_cycle", {57'd0, busy, mem_we, clear_done, cr_gnt, dbg_gnt, 2'd0} |
                         {mem_wdata, 37'd0, mem_addr},
          {57'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0} | {16'd0, 37'd0, 11'(first + i)});
      @(posedge clk); #1;
    end
    if (expect_done) begin
      @(negedge clk);
      chk("clear_done_pulse", {60'd0, clear_done, busy, cr_gnt, dbg_gnt}, {60'd0, 4'b1000});
      @(posedge clk); #1;
    end
  endtask

  function automatic vec_t mk(input logic cq, input logic cw, input int ca, input int cd,
                              input logic dq, input int da,
                              input logic ecg, input logic edg, input logic ewe, input int ea,
                              input int ewd, input logic ecv, input int ecd,
                              input logic edv, input int edd);
    vec_t v;
    v.cr_req = cq; v.cr_we = cw; v.cr_addr = 11'(ca); v.cr_wdata = 16'(cd);
    v.dbg_req = dq; v.dbg_addr = 11'(da);
    v.e_cr_gnt = ecg; v.e_dbg_gnt = edg; v.e_we = ewe; v.e_addr = 11'(ea);
    v.e_wdata = 16'(ewd); v.e_cr_rv = ecv; v.e_cr_rd = 16'(ecd);
    v.e_dbg_rv = edv; v.e_dbg_rd = 16'(edd);
    return v;
  endfunction

  initial begin
    // cr_req cr_we cr_addr cr_wdata dbg_req dbg_addr | cr_gnt dbg_gnt we addr wdata cr_rv cr_rd dbg_rv dbg_rd
    vecs[0]  = mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 2047, 0,      0, 0,      0, 0);
    vecs[1]  = mk(1, 1, 5, 16'h1234, 0, 0, 1, 0, 1, 5, 16'h1234, 0, 0,      0, 0);
    vecs[2]  = mk(1, 0, 5, 0,      0, 0,  1, 0, 0, 5, 0,         0, 0,      0, 0);
    vecs[3]  = mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 5, 0,         1, 16'h1234, 0, 0);
    vecs[4]  = mk(1, 1, 7, 16'hBEEF, 0, 0, 1, 0, 1, 7, 16'hBEEF, 0, 16'h1234, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,      1, 7,  0, 1, 0, 7, 0,         0, 16'h1234, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 7, 0,         0, 16'h1234, 1, 16'hBEEF);
    vecs[7]  = mk(1, 1, 9, 16'h00A5, 1, 5, 1, 0, 1, 9, 16'h00A5, 0, 16'h1234, 0, 16'hBEEF);
    vecs[8]  = mk(1, 0, 9, 0,      0, 0,  1, 0, 0, 9, 0,         0, 16'h1234, 0, 16'hBEEF);
    vecs[9]  = mk(1, 0, 7, 0,      1, 5,  1, 0, 0, 7, 0,         1, 16'h00A5, 0, 16'hBEEF);
    vecs[10] = mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 7, 0,         1, 16'hBEEF, 0, 16'hBEEF);
    vecs[11] = mk(0, 0, 0, 0,      1, 9,  0, 1, 0, 9, 0,         0, 16'hBEEF, 0, 16'hBEEF);
    vecs[12] = mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 9, 0,         0, 16'hBEEF, 1, 16'h00A5);

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_ctrl", outs_a(), 64'd0);
    chk("reset_data", outs_b(), 64'd0);
    @(posedge clk); #1;
    reset_N = 1'b0;
    @(posedge clk); #1;

    // Full zero-fill after reset
    pulse_start();
    clear_walk(0, 2048, 1'b1);
    @(negedge clk);
    chk("serve_after_clear", {62'd0, clear_done, busy}, 64'd0);

    // Arbitration and read-return table
    for (int i = 0; i < 13; i++) begin
      cr_req   = vecs[i].cr_req;
      cr_we    = vecs[i].cr_we;
      cr_addr  = vecs[i].cr_addr;
      cr_wdata = vecs[i].cr_wdata;
      dbg_req  = vecs[i].dbg_req;
      dbg_addr = vecs[i].dbg_addr;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {cr_gnt, dbg_gnt, mem_we, mem_addr, (mem_we ? mem_wdata : 16'd0),
           cr_rvalid, cr_rdata, dbg_rvalid, dbg_rdata},
          {vecs[i].e_cr_gnt, vecs[i].e_dbg_gnt, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
           vecs[i].e_cr_rv, vecs[i].e_cr_rd, vecs[i].e_dbg_rv, vecs[i].e_dbg_rd});
      @(posedge clk); #1;
    end

    // Starvation: debug wins on the 9th contended cycle
    cr_req = 1'b1; cr_we = 1'b0; cr_addr = 11'd3;
    dbg_req = 1'b1; dbg_addr = 11'd7;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k < 9) begin
        chk($sformatf("starve_deny%0d", k), {62'd0, cr_gnt, dbg_gnt}, {62'd0, 2'b10});
      end else begin
        chk("starve_grant", {51'd0, cr_gnt, dbg_gnt, mem_we, mem_addr[9:0]},
            {51'd0, 1'b0, 1'b1, 1'b0, 10'd7});
      end
      @(posedge clk); #1;
    end
    cr_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    chk("starve_rvalid", {47'd0, dbg_rvalid, dbg_rdata}, {47'd0, 1'b1, 16'hBEEF});
    @(posedge clk); #1;

    // start_clear in SERVE with a read in flight, requests held through CLEAR
    start_clear = 1'b1;
    cr_req = 1'b1; cr_we = 1'b0; cr_addr = 11'd5;
    dbg_req = 1'b1; dbg_addr = 11'd7;
    @(negedge clk);
    chk("inflight_gnt", {62'd0, cr_gnt, dbg_gnt}, {62'd0, 2'b10});
    @(posedge clk); #1;
    start_clear = 1'b0;
    #1;
    chk("inflight_rvalid", {47'd0, cr_rvalid, cr_rdata}, {47'd0, 1'b1, 16'h1234});
    clear_walk(0, 2048, 1'b1);
    @(negedge clk);
    chk("gnt_after_clear", {62'd0, cr_gnt, dbg_gnt}, {62'd0, 2'b10});
    @(posedge clk); #1;
    cr_req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1;

    // Restart at clear count 500
    pulse_start();
    clear_walk(0, 500, 1'b0);
    start_clear = 1'b1;
    @(negedge clk);
    chk("restart_addr", {53'd0, mem_addr}, {53'd0, 11'd500});
    @(posedge clk); #1;
    start_clear = 1'b0;
    clear_walk(0, 2048, 1'b1);

    // Reset at clear count 1000
    pulse_start();
    clear_walk(0, 1000, 1'b0);
    reset_N = 1'b1;
    #1;
    chk("midclear_reset_ctrl", outs_a(), 64'd0);
    chk("midclear_reset_data", outs_b(), 64'd0);
    @(posedge clk); #1;
    reset_N = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_no_done", {62'd0, clear_done, busy}, 64'd0);
      @(posedge clk); #1;
    end
    pulse_start();
    clear_walk(0, 2048, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
